// File: rtl/rng_pkg.sv
// Shared definitions for the ranged random-number source.
//   lfsr_taps : maximal-length Fibonacci tap masks for widths 4..16
//   state_e   : draw FSM states
//   *_ok      : parameter legality helpers used at elaboration
package rng_pkg;

    localparam int unsigned MIN_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        VALID = 2'd2
    } state_e;

    // Bit i set means register bit i feeds the XOR; new bit enters at bit 0.
    function automatic logic [MAX_WIDTH-1:0] lfsr_taps(input int unsigned width);
        logic [MAX_WIDTH-1:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
    endfunction

    // Range must exceed half the output span so a rejection is always rarer than an accept.
    function automatic bit range_ok(input int unsigned out_w, input int unsigned range);
        if (out_w < 1 || out_w > MAX_WIDTH) return 1'b0;
        return (range > (32'd1 << (out_w - 1))) && (range <= (32'd1 << out_w));
    endfunction

    function automatic bit seed_ok(input int unsigned width, input int unsigned seed);
        return seed < (32'd1 << width);
    endfunction

    // Zero would lock the LFSR, so it is silently promoted to one.
    function automatic int unsigned seed_fix(input int unsigned seed);
        return (seed == 0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with seed load and step enable.
//   clk, rst_n : clock, async active-low reset (state <- SEED, zero promoted to 1)
//   step       : advance one position this edge
//   load       : load seed this edge (wins over step; zero seed loads 1)
//   seed       : value to load
//   state      : current register contents
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(seed_fix(SEED));

    logic             fb;
    logic [WIDTH-1:0] state_d;

    assign fb = ^(state & TAPS);

    // Next-state selection: load beats step beats hold.
    always_comb begin
        state_d = state;
        if (load) begin
            state_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            state_d = {state[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_VAL;
        end else begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/rng_range.sv
// Unbiased draw in [0, RANGE) from a free-running LFSR by rejection sampling.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : free-run LFSR advance while not drawing
//   seed_load_i   : load seed_i into the LFSR (zero loads 1)
//   seed_i        : seed value
//   req_i         : draw request (sampled in IDLE, or in VALID together with ready_i)
//   ready_i       : consumer accepts num_o
//   valid_o       : num_o holds a valid draw
//   num_o         : drawn number, 0..RANGE-1
//   lfsr_o        : raw LFSR state
//   fallback_o    : one-cycle pulse when the draw was resolved by fallback
//   reject_cnt_o  : saturating count of rejected candidates
module rng_range
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned RANGE     = 10,
    parameter int unsigned SEED      = 1,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [OUT_W-1:0] num_o,
    output logic [WIDTH-1:0] lfsr_o,
    output logic             fallback_o,
    output logic [CNT_W-1:0] reject_cnt_o
);

    localparam int unsigned CAND_W  = OUT_W + 1;
    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

    localparam logic [CAND_W-1:0]  RANGE_C    = CAND_W'(RANGE);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    // Parameter legality.
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("rng_range: WIDTH must be within 4..16");
    end
    if (OUT_W > WIDTH || !range_ok(OUT_W, RANGE)) begin : g_bad_range
        $error("rng_range: need OUT_W <= WIDTH and 2^(OUT_W-1) < RANGE <= 2^OUT_W");
    end
    if (!seed_ok(WIDTH, SEED)) begin : g_bad_seed
        $error("rng_range: SEED does not fit in WIDTH bits");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("rng_range: MAX_TRIES must be at least 1");
    end

    state_e             state_q;
    state_e             state_d;
    logic [TRIES_W-1:0] tries_q;
    logic [TRIES_W-1:0] tries_d;
    logic [TRIES_W-1:0] tries_inc;
    logic               valid_d;
    logic [OUT_W-1:0]   num_d;
    logic               fallback_d;
    logic [CNT_W-1:0]   reject_cnt_d;

    logic [OUT_W-1:0]   cand;
    logic [CAND_W-1:0]  cand_ext;
    logic               cand_ok;
    logic [OUT_W-1:0]   cand_wrap;
    logic               advance;

    // Candidate is the low bits of the current LFSR state.
    assign cand      = lfsr_o[OUT_W-1:0];
    assign cand_ext  = {1'b0, cand};
    assign cand_ok   = cand_ext < RANGE_C;
    // A rejected candidate lies in [RANGE, 2^OUT_W), so subtracting RANGE lands inside the range.
    assign cand_wrap = OUT_W'(cand_ext - RANGE_C);
    assign tries_inc = tries_q + TRIES_W'(1);

    // The LFSR always moves while drawing so each attempt sees a fresh candidate.
    assign advance = (state_q == DRAW) || en_i;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .step  (advance),
        .load  (seed_load_i),
        .seed  (seed_i),
        .state (lfsr_o)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, attempt counter and next output values.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        valid_d      = valid_o;
        num_d        = num_o;
        fallback_d   = 1'b0;
        reject_cnt_d = reject_cnt_o;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = DRAW;
                    tries_d = '0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    num_d   = cand;
                    valid_d = 1'b1;
                    state_d = VALID;
                end else begin
                    if (reject_cnt_o != CNT_MAX) begin
                        reject_cnt_d = reject_cnt_o + CNT_W'(1);
                    end
                    tries_d = tries_inc;
                    if (tries_inc == TRIES_LAST) begin
                        num_d      = cand_wrap;
                        fallback_d = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = VALID;
                    end
                end
            end
            VALID: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    tries_d = '0;
                    state_d = req_i ? DRAW : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and attempt counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tries_q      <= '0;
            valid_o      <= 1'b0;
            num_o        <= '0;
            fallback_o   <= 1'b0;
            reject_cnt_o <= '0;
        end else begin
            tries_q      <= tries_d;
            valid_o      <= valid_d;
            num_o        <= num_d;
            fallback_o   <= fallback_d;
            reject_cnt_o <= reject_cnt_d;
        end
    end

endmodule

// File: tb/tb_rng_range.sv
// Bench for rng_range with WIDTH=4, OUT_W=2, RANGE=3, SEED=1, MAX_TRIES=2.
// The reference model tracks the LFSR as a position in the published 15-state sequence.
module tb_rng_range;

    localparam int W_P     = 4;
    localparam int OW_P    = 2;
    localparam int RANGE_P = 3;
    localparam int TRIES_P = 2;
    localparam int PERIOD  = 15;
    localparam int SEQ [0:14] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

    localparam int M_IDLE  = 0;
    localparam int M_DRAW  = 1;
    localparam int M_HOLD  = 2;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            en_i = 1'b0;
    logic            seed_load_i = 1'b0;
    logic [W_P-1:0]  seed_i = '0;
    logic            req_i = 1'b0;
    logic            ready_i = 1'b0;
    logic            valid_o;
    logic [OW_P-1:0] num_o;
    logic [W_P-1:0]  lfsr_o;
    logic            fallback_o;
    logic [7:0]      reject_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_idx   = 0;
    int m_mode  = M_IDLE;
    int m_valid = 0;
    int m_num   = 0;
    int m_fb    = 0;
    int m_rej   = 0;
    int m_tries = 0;
    int cand;
    int adv;

    rng_range #(
        .WIDTH     (W_P),
        .OUT_W     (OW_P),
        .RANGE     (RANGE_P),
        .SEED      (1),
        .MAX_TRIES (TRIES_P)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .seed_load_i  (seed_load_i),
        .seed_i       (seed_i),
        .req_i        (req_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .num_o        (num_o),
        .lfsr_o       (lfsr_o),
        .fallback_o   (fallback_o),
        .reject_cnt_o (reject_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int idx_of(input int v);
        for (int i = 0; i < PERIOD; i++) begin
            if (SEQ[i] == v) return i;
        end
        return 0;
    endfunction

    // Reference model update on each rising edge, comparison on each falling edge.
    initial begin : model_cmp
        forever begin
            @(posedge clk);
            if (!rst_ni) begin
                m_idx = 0; m_mode = M_IDLE; m_valid = 0; m_num = 0;
                m_fb = 0; m_rej = 0; m_tries = 0;
            end else begin
                cand = SEQ[m_idx] % (1 << OW_P);
                adv  = (m_mode == M_DRAW || en_i) ? 1 : 0;
                m_fb = 0;
                if (m_mode == M_IDLE) begin
                    if (req_i) begin
                        m_mode = M_DRAW;
                        m_tries = 0;
                    end
                end else if (m_mode == M_DRAW) begin
                    if (cand < RANGE_P) begin
                        m_num = cand; m_valid = 1; m_mode = M_HOLD;
                    end else begin
                        m_rej = (m_rej < 255) ? m_rej + 1 : 255;
                        m_tries++;
                        if (m_tries == TRIES_P) begin
                            m_num = cand - RANGE_P; m_fb = 1; m_valid = 1; m_mode = M_HOLD;
                        end
                    end
                end else begin
                    if (ready_i) begin
                        m_valid = 0;
                        m_mode = req_i ? M_DRAW : M_IDLE;
                        m_tries = 0;
                    end
                end
                if (seed_load_i) m_idx = idx_of((seed_i == 0) ? 1 : int'(seed_i));
                else if (adv != 0) m_idx = (m_idx + 1) % PERIOD;
            end
            @(negedge clk);
            check("model_valid", int'(valid_o), m_valid);
            check("model_lfsr", int'(lfsr_o), SEQ[m_idx]);
            check("model_fallback", int'(fallback_o), m_fb);
            check("model_reject_cnt", int'(reject_cnt_o), m_rej);
            if (m_valid != 0) check("model_num", int'(num_o), m_num);
        end
    end

    // Advance past one rising edge; inputs change just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        en_i = 1'b0; seed_load_i = 1'b0; seed_i = '0; req_i = 1'b0; ready_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic load_seed(input int s);
        seed_load_i = 1'b1;
        seed_i = W_P'(s);
        tick();
        seed_load_i = 1'b0;
    endtask

    initial begin : stim
        #1;
        do_reset();

        // Reset values
        check("rst_lfsr", int'(lfsr_o), 1);
        check("rst_valid", int'(valid_o), 0);
        check("rst_num", int'(num_o), 0);
        check("rst_fallback", int'(fallback_o), 0);
        check("rst_reject_cnt", int'(reject_cnt_o), 0);

        // Full period with free-run enabled
        en_i = 1'b1;
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            check("period_lfsr", int'(lfsr_o), SEQ[i % PERIOD]);
            check("period_nonzero", int'(lfsr_o != '0), 1);
        end
        en_i = 1'b0;

        // Draw from seed 1: accepted on the first attempt
        do_reset();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        check("d1_valid_early", int'(valid_o), 0);
        tick();
        check("d1_valid", int'(valid_o), 1);
        check("d1_num", int'(num_o), 1);
        check("d1_reject_cnt", int'(reject_cnt_o), 0);

        // Seed 3: one rejection, then 2 accepted
        do_reset();
        load_seed(3);
        check("d2_seed", int'(lfsr_o), 3);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        check("d2_valid_mid", int'(valid_o), 0);
        check("d2_lfsr_mid", int'(lfsr_o), 6);
        check("d2_reject_mid", int'(reject_cnt_o), 1);
        tick();
        check("d2_valid", int'(valid_o), 1);
        check("d2_num", int'(num_o), 2);
        check("d2_reject_cnt", int'(reject_cnt_o), 1);
        check("d2_fallback", int'(fallback_o), 0);

        // Seed 7: two rejections, fallback to 3-3=0
        do_reset();
        load_seed(7);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        check("d3_valid_mid", int'(valid_o), 0);
        check("d3_lfsr_mid", int'(lfsr_o), 15);
        tick();
        check("d3_valid", int'(valid_o), 1);
        check("d3_num", int'(num_o), 0);
        check("d3_fallback", int'(fallback_o), 1);
        check("d3_reject_cnt", int'(reject_cnt_o), 2);
        tick();
        check("d3_fallback_pulse", int'(fallback_o), 0);
        check("d3_valid_hold", int'(valid_o), 1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("d3_valid_drop", int'(valid_o), 0);

        // Backpressure, then back-to-back draw
        do_reset();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        check("bp_valid", int'(valid_o), 1);
        en_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_stable", int'(valid_o), 1);
            check("bp_num_stable", int'(num_o), 1);
        end
        check("bp_lfsr", int'(lfsr_o), 15);
        en_i = 1'b0;
        ready_i = 1'b1;
        req_i = 1'b1;
        tick();
        ready_i = 1'b0;
        req_i = 1'b0;
        check("bp_valid_gap", int'(valid_o), 0);
        tick();
        check("bp_valid_reject", int'(valid_o), 0);
        tick();
        check("bp_valid2", int'(valid_o), 1);
        check("bp_num2", int'(num_o), 2);
        check("bp_reject_cnt", int'(reject_cnt_o), 1);

        // Zero seed loads 1
        do_reset();
        load_seed(9);
        check("seed9", int'(lfsr_o), 9);
        load_seed(0);
        check("seed0", int'(lfsr_o), 1);

        // Async reset while drawing
        do_reset();
        load_seed(7);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        #1;
        check("rst_draw_valid", int'(valid_o), 0);
        check("rst_draw_lfsr", int'(lfsr_o), 1);
        check("rst_draw_reject", int'(reject_cnt_o), 0);
        tick();
        rst_ni = 1'b1;

        // Async reset while holding a result
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        tick();
        check("pre_rst_valid", int'(valid_o), 1);
        rst_ni = 1'b0;
        #1;
        check("rst_valid_valid", int'(valid_o), 0);
        check("rst_valid_num", int'(num_o), 0);
        check("rst_valid_lfsr", int'(lfsr_o), 1);
        tick();
        rst_ni = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_ni = 1'b0;
                tick();
                rst_ni = 1'b1;
            end
            en_i        = ($urandom_range(0, 1) == 1);
            seed_load_i = ($urandom_range(0, 11) == 0);
            seed_i      = W_P'($urandom_range(0, 15));
            req_i       = ($urandom_range(0, 9) < 4);
            ready_i     = ($urandom_range(0, 9) < 6);
            tick();
        end
        en_i = 1'b0; seed_load_i = 1'b0; req_i = 1'b0; ready_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
